// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types for the system RAM arbiter: grant selection, return-pipe
//   tag encoding and the legal RAM read latency range.
package ram_arbiter_pkg;

  // Which requester owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_VID  = 2'd2
  } grant_e;

  // Owner of a read travelling through the return pipe.
  typedef enum logic {
    TAG_CPU = 1'b0,
    TAG_VID = 1'b1
  } tag_e;

  // Registered-read RAM latency supported by the return pipe.
  localparam int unsigned RAM_LATENCY_MIN = 1;
  localparam int unsigned RAM_LATENCY_MAX = 3;

endpackage

// File: rtl/ram_arbiter_rd_return_pipe.sv
// rd_return_pipe
//   Delay line of {valid, tag} matching the RAM read latency, so the arbiter
//   knows which requester owns ram_rd_data in the cycle it becomes valid.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (clears all stages)
//   i_valid        a read was issued to the RAM this cycle
//   i_tag          owner of that read
//   o_valid        ram_rd_data holds returned data this cycle
//   o_tag          owner of that returned data
module rd_return_pipe
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  tag_e i_tag,
  output logic o_valid,
  output tag_e o_tag
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_tag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = tag_e'(r_tag[DEPTH-1]);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port system RAM between the CPU (one-cycle strobes,
//   ready handshake) and the video fetch (level request, ack/valid). Video
//   has fixed priority; a saturating wait counter forces a CPU grant after
//   MAX_CPU_WAIT lost cycles so the CPU cannot starve.
// Ports:
//   sys_clk, reset                         clock, async active-high reset
//   cpu_addr/cpu_rd_req/cpu_wr_en/cpu_wr_data  CPU request side
//   cpu_ready, cpu_rd_data                 CPU completion and read data
//   vid_addr, vid_rd_req                   video request side
//   vid_ack                                video address issued this cycle
//   vid_rd_valid, vid_rd_data              video read return (one-cycle pulse)
//   ram_addr/ram_wr_data/ram_wren          RAM command (combinational)
//   ram_rd_data                            RAM registered read data
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RAM_LATENCY  = 1,  // legal RAM_LATENCY_MIN..RAM_LATENCY_MAX
  parameter int unsigned MAX_CPU_WAIT = 4   // >= 1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd_req,
  input  logic                  cpu_wr_en,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  input  logic                  vid_rd_req,
  output logic                  vid_ack,
  output logic                  vid_rd_valid,
  output logic [DATA_WIDTH-1:0] vid_rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned        WAIT_W   = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  logic                  r_cpu_pend;
  logic                  r_cpu_is_wr;
  logic                  r_cpu_ready;
  logic [WAIT_W-1:0]     r_wait;
  logic [DATA_WIDTH-1:0] r_cpu_rd_data;
  logic                  r_vid_rd_valid;
  logic [DATA_WIDTH-1:0] r_vid_rd_data;

  grant_e w_grant;
  logic   w_issue_valid;
  tag_e   w_issue_tag;
  logic   w_ret_valid;
  tag_e   w_ret_tag;
  logic   w_cpu_capture;

  // Grant is forced to NONE during reset so no write or ack leaks out
  // while the registers are being cleared.
  always_comb begin
    w_grant = GNT_NONE;
    if (!reset) begin
      if (r_cpu_pend && ((r_wait == WAIT_MAX) || !vid_rd_req)) begin
        w_grant = GNT_CPU;
      end else if (vid_rd_req) begin
        w_grant = GNT_VID;
      end
    end
  end

  always_comb begin
    ram_addr      = cpu_addr;
    ram_wren      = 1'b0;
    vid_ack       = 1'b0;
    w_issue_valid = 1'b0;
    w_issue_tag   = TAG_CPU;
    unique case (w_grant)
      GNT_CPU: begin
        ram_wren      = r_cpu_is_wr;
        w_issue_valid = !r_cpu_is_wr;
      end
      GNT_VID: begin
        ram_addr      = vid_addr;
        vid_ack       = 1'b1;
        w_issue_valid = 1'b1;
        w_issue_tag   = TAG_VID;
      end
      default: ;
    endcase
  end

  assign ram_wr_data = cpu_wr_data;

  // cpu_ready is low exactly while an access is pending or in flight, so it
  // doubles as the "accept a new strobe" condition.
  assign w_cpu_capture = r_cpu_ready && (cpu_rd_req || cpu_wr_en);

  rd_return_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rd_return_pipe (
    .i_clk   (sys_clk),
    .i_rst   (reset),
    .i_valid (w_issue_valid),
    .i_tag   (w_issue_tag),
    .o_valid (w_ret_valid),
    .o_tag   (w_ret_tag)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cpu_pend    <= 1'b0;
      r_cpu_is_wr   <= 1'b0;
      r_cpu_ready   <= 1'b1;
      r_wait        <= '0;
      r_cpu_rd_data <= '0;
    end else begin
      if (w_cpu_capture) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_is_wr <= cpu_wr_en;  // write wins when both strobes are high
        r_cpu_ready <= 1'b0;
        r_wait      <= '0;
      end else if (w_grant == GNT_CPU) begin
        r_cpu_pend <= 1'b0;
        r_wait     <= '0;
        if (r_cpu_is_wr) begin
          r_cpu_ready <= 1'b1;
        end
      end else if (r_cpu_pend && (w_grant == GNT_VID) && (r_wait != WAIT_MAX)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end

      // Only one CPU access exists at a time, so a CPU return never
      // coincides with a capture or a CPU grant.
      if (w_ret_valid && (w_ret_tag == TAG_CPU)) begin
        r_cpu_rd_data <= ram_rd_data;
        r_cpu_ready   <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_vid_rd_valid <= 1'b0;
      r_vid_rd_data  <= '0;
    end else begin
      r_vid_rd_valid <= w_ret_valid && (w_ret_tag == TAG_VID);
      if (w_ret_valid && (w_ret_tag == TAG_VID)) begin
        r_vid_rd_data <= ram_rd_data;
      end
    end
  end

  assign cpu_ready    = r_cpu_ready;
  assign cpu_rd_data  = r_cpu_rd_data;
  assign vid_rd_valid = r_vid_rd_valid;
  assign vid_rd_data  = r_vid_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT with RAM_LATENCY=1
  logic [15:0] cpu_addr, vid_addr, ram_addr;
  logic        cpu_rd_req, cpu_wr_en, cpu_ready, vid_rd_req, vid_ack, vid_rd_valid, ram_wren;
  logic [7:0]  cpu_wr_data, cpu_rd_data, vid_rd_data, ram_wr_data, ram_rd_data;

  // DUT with RAM_LATENCY=3 (video-only, used for the reset scenario)
  logic [15:0] cpu_addr3, vid_addr3, ram_addr3;
  logic        cpu_rd_req3, cpu_wr_en3, cpu_ready3, vid_rd_req3, vid_ack3, vid_rd_valid3, ram_wren3;
  logic [7:0]  cpu_wr_data3, cpu_rd_data3, vid_rd_data3, ram_wr_data3, ram_rd_data3;

  ram_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .RAM_LATENCY(1), .MAX_CPU_WAIT(4)
  ) dut1 (
    .sys_clk(clk), .reset(rst),
    .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data), .cpu_ready(cpu_ready), .cpu_rd_data(cpu_rd_data),
    .vid_addr(vid_addr), .vid_rd_req(vid_rd_req), .vid_ack(vid_ack),
    .vid_rd_valid(vid_rd_valid), .vid_rd_data(vid_rd_data),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wren(ram_wren),
    .ram_rd_data(ram_rd_data)
  );

  ram_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .RAM_LATENCY(3), .MAX_CPU_WAIT(4)
  ) dut3 (
    .sys_clk(clk), .reset(rst),
    .cpu_addr(cpu_addr3), .cpu_rd_req(cpu_rd_req3), .cpu_wr_en(cpu_wr_en3),
    .cpu_wr_data(cpu_wr_data3), .cpu_ready(cpu_ready3), .cpu_rd_data(cpu_rd_data3),
    .vid_addr(vid_addr3), .vid_rd_req(vid_rd_req3), .vid_ack(vid_ack3),
    .vid_rd_valid(vid_rd_valid3), .vid_rd_data(vid_rd_data3),
    .ram_addr(ram_addr3), .ram_wr_data(ram_wr_data3), .ram_wren(ram_wren3),
    .ram_rd_data(ram_rd_data3)
  );

  // RAM model, latency 1. Command sampled mid-cycle, applied at the edge.
  logic [7:0] mem1 [0:65535];
  initial begin : ram1_model
    logic [15:0] sa;
    logic        sw;
    logic [7:0]  sd;
    for (int i = 0; i < 65536; i++) mem1[i] = 8'(i ^ (i >> 8));
    mem1[16'h1234] = 8'hA5;
    mem1[16'h0100] = 8'h11;
    mem1[16'h0101] = 8'h22;
    mem1[16'h0102] = 8'h33;
    mem1[16'h0103] = 8'h44;
    mem1[16'h0200] = 8'hC3;
    ram_rd_data <= '0;
    forever begin
      @(negedge clk);
      sa = ram_addr; sw = ram_wren; sd = ram_wr_data;
      @(posedge clk);
      ram_rd_data <= mem1[sa];
      if (sw) mem1[sa] = sd;
    end
  end

  // RAM model, latency 3.
  logic [7:0] mem3 [0:65535];
  initial begin : ram3_model
    logic [15:0] sa;
    logic        sw;
    logic [7:0]  sd, p0, p1;
    for (int i = 0; i < 65536; i++) mem3[i] = 8'(i + 1);
    mem3[16'h0300] = 8'h96;
    p0 = '0; p1 = '0;
    ram_rd_data3 <= '0;
    forever begin
      @(negedge clk);
      sa = ram_addr3; sw = ram_wren3; sd = ram_wr_data3;
      @(posedge clk);
      ram_rd_data3 <= p1;
      p1 = p0;
      p0 = mem3[sa];
      if (sw) mem3[sa] = sd;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Moves to 1 time unit after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full CPU read: strobe in cycle 0, issue in 1, ready+data in 3.
  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    next_cycle();
    cpu_addr = a; cpu_rd_req = 1'b1;
    next_cycle();
    cpu_rd_req = 1'b0;
    #1;
    check({tag, "_rdy_c1"},  32'(cpu_ready), 0);
    check({tag, "_addr_c1"}, 32'(ram_addr), 32'(a));
    check({tag, "_wren_c1"}, 32'(ram_wren), 0);
    next_cycle(); #1;
    check({tag, "_rdy_c2"}, 32'(cpu_ready), 0);
    next_cycle(); #1;
    check({tag, "_rdy_c3"},  32'(cpu_ready), 1);
    check({tag, "_data_c3"}, 32'(cpu_rd_data), 32'(exp));
  endtask

  logic [7:0] vexp [4];

  initial begin
    vexp = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    cpu_addr = '0; cpu_rd_req = 1'b0; cpu_wr_en = 1'b0; cpu_wr_data = '0;
    vid_addr = 16'h0100; vid_rd_req = 1'b1;
    cpu_addr3 = '0; cpu_rd_req3 = 1'b0; cpu_wr_en3 = 1'b0; cpu_wr_data3 = '0;
    vid_addr3 = 16'h0300; vid_rd_req3 = 1'b1;

    // Reset state, with video requesting to show the grant is suppressed.
    next_cycle(); #1;
    check("rst_vid_ack",  32'(vid_ack), 0);
    check("rst_wren",     32'(ram_wren), 0);
    check("rst_ready",    32'(cpu_ready), 1);
    check("rst_rd_data",  32'(cpu_rd_data), 0);
    check("rst_vvalid",   32'(vid_rd_valid), 0);
    check("rst_vdata",    32'(vid_rd_data), 0);
    check("rst_vid_ack3", 32'(vid_ack3), 0);
    vid_rd_req = 1'b0; vid_rd_req3 = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // CPU read
    cpu_read(16'h1234, 8'hA5, "rd1234");

    // CPU write, with a read strobe during the in-flight cycle that must be ignored
    next_cycle();
    cpu_addr = 16'h8F00; cpu_wr_en = 1'b1; cpu_wr_data = 8'h3C;
    next_cycle();
    cpu_wr_en = 1'b0; cpu_rd_req = 1'b1;
    #1;
    check("wr_wren_c1",  32'(ram_wren), 1);
    check("wr_addr_c1",  32'(ram_addr), 'h8F00);
    check("wr_wdata_c1", 32'(ram_wr_data), 'h3C);
    check("wr_rdy_c1",   32'(cpu_ready), 0);
    next_cycle();
    cpu_rd_req = 1'b0;
    #1;
    check("wr_wren_c2", 32'(ram_wren), 0);
    check("wr_rdy_c2",  32'(cpu_ready), 1);
    next_cycle(); #1;
    check("wr_ign_rdy_c3", 32'(cpu_ready), 1);
    cpu_read(16'h8F00, 8'h3C, "rd8F00");

    // Video stream 0x0100..0x0103
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      vid_rd_req = (c < 4);
      vid_addr   = 16'(16'h0100 + c);
      #1;
      check($sformatf("vs_ack_c%0d", c), 32'(vid_ack), 32'(c < 4));
      if (c < 4) check($sformatf("vs_addr_c%0d", c), 32'(ram_addr), 32'(16'h0100 + c));
      check($sformatf("vs_valid_c%0d", c), 32'(vid_rd_valid), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) check($sformatf("vs_data_c%0d", c), 32'(vid_rd_data), 32'(vexp[c-2]));
    end
    vid_rd_req = 1'b0;

    // Starvation bound: CPU pending from cycle 1, granted in cycle 5
    next_cycle();
    vid_rd_req = 1'b1; vid_addr = 16'h0200;
    cpu_addr = 16'h1234; cpu_rd_req = 1'b1;
    #1;
    check("st_ack_c0", 32'(vid_ack), 1);
    for (int c = 1; c < 8; c++) begin
      next_cycle();
      cpu_rd_req = 1'b0;
      #1;
      check($sformatf("st_ack_c%0d", c), 32'(vid_ack), 32'(c != 5));
      check($sformatf("st_rdy_c%0d", c), 32'(cpu_ready), 32'(c == 7));
      if (c == 5) check("st_addr_c5", 32'(ram_addr), 'h1234);
      if (c == 7) check("st_data_c7", 32'(cpu_rd_data), 'hA5);
    end
    vid_rd_req = 1'b0;
    next_cycle();
    next_cycle();

    // Simultaneous rd+wr strobe: a single write, no read return
    next_cycle();
    cpu_addr = 16'h0010; cpu_rd_req = 1'b1; cpu_wr_en = 1'b1; cpu_wr_data = 8'h77;
    next_cycle();
    cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
    #1;
    check("rw_wren_c1",  32'(ram_wren), 1);
    check("rw_addr_c1",  32'(ram_addr), 'h0010);
    check("rw_wdata_c1", 32'(ram_wr_data), 'h77);
    next_cycle(); #1;
    check("rw_rdy_c2",  32'(cpu_ready), 1);
    check("rw_wren_c2", 32'(ram_wren), 0);
    next_cycle(); #1;
    check("rw_rdy_c3",  32'(cpu_ready), 1);
    check("rw_nodata_c3", 32'(cpu_rd_data), 'hA5);
    cpu_read(16'h0010, 8'h77, "rd0010");

    // Reset one cycle after a video ack, latency 3
    next_cycle();
    vid_rd_req3 = 1'b1; vid_addr3 = 16'h0300;
    #1;
    check("rs_ack3_c0", 32'(vid_ack3), 1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rs_ack3_rst",   32'(vid_ack3), 0);
    check("rs_wren3_rst",  32'(ram_wren3), 0);
    check("rs_rdy3_rst",   32'(cpu_ready3), 1);
    check("rs_valid3_rst", 32'(vid_rd_valid3), 0);
    check("rs_rdy1_rst",   32'(cpu_ready), 1);
    next_cycle();
    rst = 1'b0; vid_rd_req3 = 1'b0;
    #1;
    check("rs_valid3_c2", 32'(vid_rd_valid3), 0);
    for (int k = 3; k < 8; k++) begin
      next_cycle(); #1;
      check($sformatf("rs_valid3_c%0d", k), 32'(vid_rd_valid3), 0);
    end

    // Normal latency-3 read after reset: valid exactly at T+4
    next_cycle();
    vid_rd_req3 = 1'b1; vid_addr3 = 16'h0300;
    #1;
    check("l3_ack3_T", 32'(vid_ack3), 1);
    for (int k = 1; k < 6; k++) begin
      next_cycle();
      vid_rd_req3 = 1'b0;
      #1;
      check($sformatf("l3_valid3_T%0d", k), 32'(vid_rd_valid3), 32'(k == 4));
      if (k == 4) check("l3_data3", 32'(vid_rd_data3), 'h96);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port system RAM (synchronous, registered read) between two requesters on sys_clk: the cornet CPU (pulse requests, ready handshake) and the chroni video fetch (level request, ack/valid).
- Video has fixed priority because of real-time scan-out; a wait counter bounds CPU starvation.
- Sits between cornet_cpu, chroni and the spram instance in system; address decode (ram_cs) gates the CPU strobes before they reach this block.

Parameters:
ADDR_WIDTH, 16, RAM/requester address width
DATA_WIDTH, 8, RAM data width
RAM_LATENCY, 1, cycles from issued address to valid ram_rd_data; legal 1..3
MAX_CPU_WAIT, 4, maximum cycles a pending CPU access may lose to video; legal ≥1

Ports:
sys_clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_WIDTH  CPU address, stable from strobe until cpu_ready=1
cpu_rd_req  in  1  one-cycle read strobe
cpu_wr_en  in  1  one-cycle write strobe
cpu_wr_data  in  DATA_WIDTH  write data, stable with cpu_addr
cpu_ready  out  1  0 while a CPU access is pending or in flight
cpu_rd_data  out  DATA_WIDTH  registered read data, valid when cpu_ready rises after a read
vid_addr  in  ADDR_WIDTH  video fetch address, stable while vid_rd_req=1 and not acked
vid_rd_req  in  1  level read request
vid_ack  out  1  combinational: video address issued this cycle
vid_rd_valid  out  1  one-cycle pulse, vid_rd_data valid
vid_rd_data  out  DATA_WIDTH  registered video read data
ram_addr  out  ADDR_WIDTH  RAM address (combinational from grant)
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_wren  out  1  RAM write enable
ram_rd_data  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset values, async on reset: cpu_ready=1, cpu_rd_data=0, vid_rd_valid=0, vid_rd_data=0, CPU pending flags=0, wait counter=0, return pipe empty. Grant is NONE, so ram_wren=0 and vid_ack=0 while reset is high.
- CPU capture: a strobe sampled at edge E sets pending (rd or wr), latches the type and clears cpu_ready from E. Strobes while pending or in flight are ignored. If rd and wr are both high, the access is a write and the read is dropped.
- Grant, combinational each cycle:
  - CPU wins if CPU is pending and either wait==MAX_CPU_WAIT or vid_rd_req=0.
  - Otherwise VID wins if vid_rd_req=1.
  - Otherwise NONE.
- Issue cycle T:
  - ram_addr comes from the winner; for NONE it holds cpu_addr; ram_wren=0 unless a CPU write is granted.
  - CPU grant clears pending and wait.
  - VID grant asserts vid_ack in T. While CPU is pending and loses, wait increments, saturating at MAX_CPU_WAIT.
- Read return: the tag (CPU/VID) enters a RAM_LATENCY-deep valid+tag pipe. In cycle T+RAM_LATENCY, ram_rd_data is registered into cpu_rd_data or vid_rd_data.
  - CPU read: cpu_ready=1 from T+RAM_LATENCY+1.
  - VID read: vid_rd_valid=1 for exactly cycle T+RAM_LATENCY+1.
- CPU write: issued in T, cpu_ready=1 from T+1.
- Throughput: one RAM access per cycle. Video may take back-to-back cycles; a new video request may be acked while earlier reads are still in the pipe, and returns stay in issue order.
- Starvation bound: a CPU access is issued no later than MAX_CPU_WAIT+1 cycles after it becomes pending.
- vid_rd_req dropped before ack: no access occurs, no valid is produced.
- Reset mid-operation: in-flight reads are discarded, no valid or ready pulse follows, and pending CPU accesses are lost.

Decomposition:
- Header bus.vh (included like chroni.vh): GNT_NONE/GNT_CPU/GNT_VID grant encodings, TAG_CPU/TAG_VID tag encodings, RAM_LATENCY legal range.
- One sub-module: rd_return_pipe, a parameterised depth shift register of {valid,tag} with async reset.
- Arbitration and CPU capture stay in ram_arbiter.

Test Plan:
- CPU read only, LAT=1: RAM[0x1234]=0xA5, cpu_rd_req at cycle 0 → cpu_ready=0 cycles 1–2, ram_addr=0x1234 in cycle 1, cpu_ready=1 and cpu_rd_data=0xA5 at cycle 3.
- CPU write: cpu_wr_en, addr 0x8F00, data 0x3C at cycle 0 → ram_wren=1 only in cycle 1, cpu_ready=1 cycle 2; a subsequent read returns 0x3C.
- Video stream: vid_rd_req held, addresses 0x0100..0x0103 advanced on each vid_ack → acks in 4 consecutive cycles, vid_rd_valid in 4 consecutive cycles starting 2 cycles after the first ack, data in order.
- Starvation, MAX_CPU_WAIT=4: vid_rd_req held continuously, CPU read pending from cycle 1 → video granted cycles 1–4, CPU granted cycle 5, vid_ack=0 in cycle 5, video resumes cycle 6.
- Simultaneous rd+wr strobe at 0x0010, data 0x77 → a single write occurs, cpu_ready=1 two cycles after the strobe, no read return.
- Async reset asserted one cycle after a video ack with LAT=3 → vid_rd_valid never pulses, cpu_ready=1 immediately, ram_wren=0; normal operation resumes after deassert.
